// File: rtl/data_mem_responder_if.sv
// ----------------------------------------------------------------------------
// data_mem_responder_if
// Bundle of the MEM-stage data-memory request/response signals.
//   master : requester side (drives req_*, observes ready/resp/busy)
//   slave  : responder side (observes req_*, drives ready/resp/busy)
// Signals:
//   req_valid/req_ready  request handshake
//   req_addr             word index (not a byte address)
//   req_wdata            write data
//   req_we/req_re        write / read request qualifiers
//   resp_valid           one-cycle response strobe
//   resp_rdata/resp_err  response fields, held until the next response
//   busy                 a request is in flight
// ----------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_we;
    logic              req_re;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_re,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_re,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the MEM-stage data-memory port. Accepts one
// word-addressed read or write through a valid/ready handshake, performs it
// on an internal DEPTH x DATA_W array and answers after LATENCY cycles, so
// the pipeline's stall logic sees a slow memory.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-low
//   bus    data_mem_responder_if.slave (request/response bundle)
// Parameters:
//   DATA_W, ADDR_W, DEPTH, LATENCY (1..15)
// Notes:
//   - The array has no reset; contents survive reset.
//   - The access commits on the edge entering RESP, so a write still waiting
//     when reset arrives is dropped.
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // WAIT lasts LATENCY-1 edges: cnt counts LATENCY-2 down to 0.
    localparam logic [3:0]        CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam bit                LAT_ONE  = (LATENCY == 1);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

    // Error classification of a committed access. A no-op never errors;
    // a conflicting we/re always errors; otherwise the address must be in range.
    function automatic logic resp_err_f(input logic we, input logic re, input logic in_range);
        logic err;
        if (we && re) begin
            err = 1'b1;
        end else if (!we && !re) begin
            err = 1'b0;
        end else begin
            err = !in_range;
        end
        return err;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q,      state_d;
    logic [3:0]        cnt_q,        cnt_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic              we_q,         we_d;
    logic              re_q,         re_d;
    logic              req_ready_q,  req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q,   resp_err_d;
    logic              busy_q,       busy_d;

    logic              accept_s;
    logic              commit_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [DATA_W-1:0] acc_wdata_s;
    logic              acc_we_s;
    logic              acc_re_s;
    logic              in_range_s;
    logic [IDX_W-1:0]  idx_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              wr_en_s;

    assign accept_s = bus.req_valid & req_ready_q;

    // Next-state and request-latch logic of the IDLE/WAIT/RESP machine.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        re_d    = re_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept_s) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    we_d    = bus.req_we;
                    re_d    = bus.req_re;
                    if (LAT_ONE) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Every edge that lands in RESP is an entry into RESP and carries exactly
    // one access. With LATENCY=1 that access is the one being accepted on the
    // same edge, so its fields come straight from the bus.
    assign commit_s    = (state_d == ST_RESP);
    assign acc_addr_s  = LAT_ONE ? bus.req_addr  : addr_q;
    assign acc_wdata_s = LAT_ONE ? bus.req_wdata : wdata_q;
    assign acc_we_s    = LAT_ONE ? bus.req_we    : we_q;
    assign acc_re_s    = LAT_ONE ? bus.req_re    : re_q;

    // Full-width compare: upper address bits never alias into the array.
    assign in_range_s = (acc_addr_s < DEPTH_A);
    assign idx_s      = acc_addr_s[IDX_W-1:0];
    assign rd_word_s  = mem[idx_s];
    assign wr_en_s    = commit_s & acc_we_s & ~acc_re_s & in_range_s;

    // Registered output values; response fields only move on a commit.
    always_comb begin
        req_ready_d  = (state_d != ST_WAIT);
        resp_valid_d = commit_s;
        busy_d       = (state_d != ST_IDLE);
        if (commit_s) begin
            resp_err_d = resp_err_f(acc_we_s, acc_re_s, in_range_s);
            if (acc_re_s && !acc_we_s && in_range_s) begin
                resp_rdata_d = rd_word_s;
            end else begin
                resp_rdata_d = {DATA_W{1'b0}};
            end
        end else begin
            resp_err_d   = resp_err_q;
            resp_rdata_d = resp_rdata_q;
        end
    end

    // Control and output registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {DATA_W{1'b0}};
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            re_q         <= re_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    // Storage array write port; deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[idx_s] <= acc_wdata_s;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = busy_q;

endmodule
